dbus_router: RTL and testbench

// - Sits between the SERV CPU data bus and its two slaves: block RAM and the

---
 rtl/dbus_router_if.sv | 14 +
 rtl/dbus_router.sv | 104 ++++++++++
 tb/tb_dbus_router.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dbus_router_if.sv
// Wishbone-style data bus bundle shared by the CPU, RAM and I/O sides of dbus_router.
// The master drives the request, the slave returns rdt/ack.
interface dbus_router_if;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, sel, we, cyc, input rdt, ack);
    modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/dbus_router.sv
// Routes SERV data-bus cycles to RAM or the OR'd I/O bus, with one ack per cycle.
// Define DBUS_ROUTER_TIMEOUT_EN to terminate unacknowledged cycles and flag bus_err.
module dbus_router #(
    parameter logic [7:0]  IO_MASK     = 8'hC0,
    parameter logic [7:0]  IO_MATCH    = 8'h40,
    parameter int          TIMEOUT     = 16,
    parameter logic [31:0] TIMEOUT_RDT = 32'hDEADBEEF
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    dbus_router_if.slave  wb_cpu,
    dbus_router_if.master wb_mem,
    dbus_router_if.master wb_io,
    output logic          bus_err
);
    typedef enum logic [1:0] {IDLE, MEM, IO, DONE} state_t;

    state_t      state_q;
    logic        is_io;
    logic        in_mem;
    logic        in_io;
    logic        sel_ack;
    logic [31:0] sel_rdt;
    logic        tmo;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("dbus_router: TIMEOUT out of range 1..65535");
    end

    assign is_io  = ((wb_cpu.adr[31:24] & IO_MASK) == IO_MATCH);
    assign in_mem = (state_q == MEM);
    assign in_io  = (state_q == IO);

    // Slave cyc follows the registered target, so DONE and IDLE never reach a slave.
    assign wb_mem.cyc = wb_cpu.cyc & in_mem;
    assign wb_io.cyc  = wb_cpu.cyc & in_io;

    assign wb_mem.adr = wb_cpu.adr;
    assign wb_mem.dat = wb_cpu.dat;
    assign wb_mem.sel = wb_cpu.sel;
    assign wb_mem.we  = wb_cpu.we;
    assign wb_io.adr  = wb_cpu.adr;
    assign wb_io.dat  = wb_cpu.dat;
    assign wb_io.sel  = wb_cpu.sel;
    assign wb_io.we   = wb_cpu.we;

    assign sel_ack = (in_mem & wb_mem.ack) | (in_io & wb_io.ack);
    assign sel_rdt = in_io ? wb_io.rdt : wb_mem.rdt;

    assign wb_cpu.ack = sel_ack | tmo;
    assign wb_cpu.rdt = sel_ack ? sel_rdt : (tmo ? TIMEOUT_RDT : 32'h0);

`ifdef DBUS_ROUTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic          bus_err_q;

    // A real slave ack in the timeout cycle takes precedence over the forced one.
    assign tmo     = (in_mem | in_io) & wb_cpu.cyc & ~sel_ack & (cnt_q == CW'(TIMEOUT));
    assign bus_err = bus_err_q;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                cnt_q <= '0;
            end else if ((in_mem | in_io) & wb_cpu.cyc & ~sel_ack & ~tmo) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (tmo) begin
                bus_err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo     = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wb_cpu.cyc) begin
                        state_q <= is_io ? IO : MEM;
                    end
                end
                MEM, IO: begin
                    if (sel_ack | tmo) begin
                        state_q <= DONE;
                    end else if (!wb_cpu.cyc) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbus_router.sv
// Self-checking bench for dbus_router: directed table, timeout/reset sequences, random traffic.
module tb_dbus_router;
    logic wb_clk;
    logic wb_rst_n;
    logic bus_err;

    dbus_router_if cpu_if ();
    dbus_router_if mem_if ();
    dbus_router_if io_if ();

    dbus_router dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .wb_cpu   (cpu_if),
        .wb_mem   (mem_if),
        .wb_io    (io_if),
        .bus_err  (bus_err)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

`ifdef DBUS_ROUTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int          TMO     = 16;
    localparam logic [31:0] TMO_RDT = 32'hDEADBEEF;

    int   vectors     = 0;
    int   miscompares = 0;
    int   txn_no      = 0;
    logic exp_bus_err = 1'b0;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic        is_io;
        int          ack_k;
        logic [31:0] rdata;
        int          abort_k;
        logic        hold;
        int          spur;
    } vec_t;

    vec_t tbl [8];

    function automatic logic decode_io(input logic [31:0] adr);
        int top;
        top = int'(adr >> 24);
        return ((top & 'hC0) == 'h40);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input string name, input logic cyc, input logic mack, input logic iack,
                        input logic [31:0] mrdt, input logic [31:0] irdt,
                        input logic emc, input logic eic, input logic eack, input logic [31:0] erdt);
        cpu_if.cyc = cyc;
        mem_if.ack = mack;
        io_if.ack  = iack;
        mem_if.rdt = mrdt;
        io_if.rdt  = irdt;
        @(negedge wb_clk);
        chk({name, " slave_cyc"}, 64'({mem_if.cyc, io_if.cyc}), 64'({emc, eic}));
        chk({name, " ack_rdt"}, 64'({cpu_if.ack, cpu_if.rdt}), 64'({eack, erdt}));
        chk({name, " bus_err"}, 64'(bus_err), 64'(exp_bus_err));
        chk({name, " mem_pass"}, {mem_if.adr, mem_if.dat}, {cpu_if.adr, cpu_if.dat});
        chk({name, " io_pass"}, {io_if.adr, io_if.dat}, {cpu_if.adr, cpu_if.dat});
        chk({name, " sel_we"}, 64'({mem_if.sel, mem_if.we, io_if.sel, io_if.we}),
            64'({cpu_if.sel, cpu_if.we, cpu_if.sel, cpu_if.we}));
        @(posedge wb_clk);
        #1;
    endtask

    // Transaction model: cycle k counts from the first cycle the CPU raises cyc.
    // The target slave sees cyc from k=1, acks at ack_k (0: never), then one dead cycle.
    task automatic run_txn(input string name, input vec_t v, input int gap);
        int          k;
        logic        fin;
        logic        s_ack, o_ack, t_ack;
        logic [31:0] s_rdt, o_rdt, e_rdt;
        cpu_if.adr = v.adr;
        cpu_if.we  = v.we;
        cpu_if.dat = v.dat;
        cpu_if.sel = 4'($urandom);
        k   = 0;
        fin = 1'b0;
        while (!fin) begin
            if (v.abort_k != 0 && k == v.abort_k) begin
                step({name, " abort"}, 1'b0, 1'b0, 1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
                fin = 1'b1;
            end else begin
                s_ack = (k >= 1) && (k == v.ack_k);
                t_ack = TMO_EN && (v.ack_k == 0) && (k == TMO + 1);
                o_ack = (v.spur == 1) ? 1'b1 : (v.spur == 2) ? 1'($urandom) : 1'b0;
                s_rdt = s_ack ? v.rdata : $urandom;
                o_rdt = $urandom;
                e_rdt = s_ack ? v.rdata : (t_ack ? TMO_RDT : 32'h0);
                if (v.is_io)
                    step(name, 1'b1, o_ack, s_ack, o_rdt, s_rdt, 1'b0, k >= 1, s_ack | t_ack, e_rdt);
                else
                    step(name, 1'b1, s_ack, o_ack, s_rdt, o_rdt, k >= 1, 1'b0, s_ack | t_ack, e_rdt);
                if (t_ack) exp_bus_err = 1'b1;
                if (s_ack || t_ack) begin
                    step({name, " done"}, v.hold, 1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
                    fin = 1'b1;
                end
            end
            k++;
            if (!fin && k > 100) begin
                chk({name, " cycle_budget"}, 64'(k), 64'(100));
                fin = 1'b1;
            end
        end
        for (int g = 0; g < gap; g++)
            step({name, " gap"}, 1'b0, 1'b0, 1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
        txn_no++;
        $display("txn %0d %s adr=%h we=%0d io=%0d ack_k=%0d abort_k=%0d", txn_no, name, v.adr, v.we,
                 v.is_io, v.ack_k, v.abort_k);
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{32'h0000_0100, 1'b0, 32'h0,      1'b0, 1, 32'h1234_5678, 0, 1'b0, 0};
        tbl[1] = '{32'h5000_0000, 1'b1, 32'hA5,     1'b1, 1, 32'h0,         0, 1'b0, 0};
        tbl[2] = '{32'h4000_0000, 1'b0, 32'h0,      1'b1, 3, 32'hCAFE_0001, 0, 1'b0, 1};
        tbl[3] = '{32'h0000_0200, 1'b0, 32'h0,      1'b0, 2, 32'h0BAD_F00D, 0, 1'b1, 1};
        tbl[4] = '{32'h6000_0000, 1'b0, 32'h0,      1'b1, 5, 32'h1111_1111, 1, 1'b0, 0};
        tbl[5] = '{32'h0000_0104, 1'b0, 32'h0,      1'b0, 1, 32'h8765_4321, 0, 1'b0, 0};
        tbl[6] = '{32'h7F00_0010, 1'b0, 32'h0,      1'b1, 2, 32'h7F7F_0000, 0, 1'b0, 1};
        tbl[7] = '{32'hC000_0000, 1'b1, 32'h55AA,   1'b0, 1, 32'hC0C0_C0C0, 0, 1'b1, 1};

        wb_rst_n   = 1'b0;
        cpu_if.adr = 32'h0;
        cpu_if.dat = 32'h0;
        cpu_if.sel = 4'hF;
        cpu_if.we  = 1'b0;
        cpu_if.cyc = 1'b1;
        mem_if.ack = 1'b1;
        io_if.ack  = 1'b1;
        mem_if.rdt = 32'hFFFF_FFFF;
        io_if.rdt  = 32'hFFFF_FFFF;
        repeat (2) @(posedge wb_clk);
        @(negedge wb_clk);
        chk("reset slave_cyc", 64'({mem_if.cyc, io_if.cyc}), 64'(0));
        chk("reset ack_rdt", 64'({cpu_if.ack, cpu_if.rdt}), 64'(0));
        chk("reset bus_err", 64'(bus_err), 64'(0));
        @(posedge wb_clk);
        #1;
        cpu_if.cyc = 1'b0;
        mem_if.ack = 1'b0;
        io_if.ack  = 1'b0;
        wb_rst_n   = 1'b1;
        @(posedge wb_clk);
        #1;

        for (int i = 0; i < 8; i++)
            run_txn($sformatf("tbl%0d", i), tbl[i], 1);

        if (TMO_EN) begin
            v = '{32'h8000_0000, 1'b0, 32'h0, 1'b0, 0, 32'h0, 0, 1'b0, 0};
            run_txn("timeout", v, 0);
            wb_rst_n = 1'b0;
            #1;
            chk("timeout rst bus_err", 64'(bus_err), 64'(0));
            exp_bus_err = 1'b0;
            @(posedge wb_clk);
            #1;
            wb_rst_n = 1'b1;
            @(posedge wb_clk);
            #1;
        end

        for (int i = 0; i < 200; i++) begin
            v.adr     = $urandom;
            v.we      = 1'($urandom);
            v.dat     = $urandom;
            v.is_io   = decode_io(v.adr);
            v.ack_k   = int'($urandom_range(1, 4));
            v.rdata   = $urandom;
            v.abort_k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, v.ack_k)) : 0;
            v.hold    = 1'($urandom);
            v.spur    = 2;
            run_txn("rand", v, int'($urandom_range(0, 2)));
        end

        cpu_if.adr = 32'h0000_0100;
        step("arst0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("arst1", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        mem_if.ack = 1'b1;
        mem_if.rdt = 32'h1357_9BDF;
        wb_rst_n   = 1'b0;
        #1;
        chk("arst slave_cyc", 64'({mem_if.cyc, io_if.cyc}), 64'(0));
        chk("arst ack_rdt", 64'({cpu_if.ack, cpu_if.rdt}), 64'(0));
        mem_if.ack = 1'b0;
        cpu_if.cyc = 1'b0;
        @(posedge wb_clk);
        #1;
        wb_rst_n = 1'b1;
        @(posedge wb_clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
